pixel_frame_streamer: RTL
=========================

PIXEL_FRAME_STREAMER -- requirements
Module: pixel_frame_streamer

Interface
REQ-001 Parameter N, default 450, frame height in rows.
REQ-002 Parameter M, default 600, frame width in columns.
REQ-003 Parameter TIMEOUT, default 2**20, maximum cycles to wait for filter completion.
REQ-004 Parameter AW, default ceil(log2(N*M)), frame address width.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 load_en  in  1  frame-memory write strobe.
REQ-008 load_addr  in  AW  write address, raster order (row*M + col).
REQ-009 load_data  in  8  pixel byte to write.
REQ-010 start  in  1  request to stream one frame; sampled on the clock edge.
REQ-011 filter_done  in  1  level from the downstream edge filter; high when its frame is finished.
REQ-012 pix_valid  out  1  pixel strobe to the filter's data-valid input.
REQ-013 pix_data  out  8  pixel byte to the filter's data input.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when the filter reports completion.
REQ-016 timeout  out  1  sticky flag, set when filter_done is not seen within TIMEOUT cycles.

Function
REQ-017 Block SHALL hold an N*M x 8 frame memory with one write port and one read port; the read port is synchronous with 1-cycle latency.
REQ-018 States SHALL be IDLE, PRIME, STREAM and WAIT_DONE.
REQ-019 IDLE: load_en SHALL write load_data to load_addr; load_addr >= N*M SHALL be ignored.
REQ-020 Writes SHALL be ignored in every state other than IDLE.
REQ-021 IDLE with start=1 SHALL go to PRIME, clear timeout and issue a read of address 0.
REQ-022 start and load_en both high in IDLE SHALL perform the write; a write to address 0 SHALL be visible in the streamed frame.
REQ-023 start outside IDLE SHALL be ignored, with no queuing.
REQ-024 PRIME SHALL last exactly 1 cycle, then go to STREAM.
REQ-025 STREAM: pix_valid SHALL be high for exactly N*M consecutive cycles, with no gaps, because the filter restarts its index whenever valid drops.
REQ-026 Pixels SHALL be emitted in ascending address order 0..N*M-1; pix_data SHALL equal mem[k] on the k-th valid cycle.
REQ-027 First pix_valid SHALL be 2 cycles after the edge that samples start; the last pixel SHALL be at edge N*M+1 after it.
REQ-028 After the last pixel, the read address SHALL wrap to 0, pix_valid SHALL drop on the next cycle, and the state SHALL go to WAIT_DONE.
REQ-029 pix_data SHALL be 8'h00 whenever pix_valid is low.
REQ-030 WAIT_DONE SHALL count cycles from 0; filter_done=1 SHALL pulse frame_done for one cycle and return to IDLE.
REQ-031 If the count reaches TIMEOUT-1 without filter_done, the block SHALL set timeout, return to IDLE and not pulse frame_done.
REQ-032 filter_done and the timeout count expiring in the same cycle SHALL be treated as completion, not timeout.
REQ-033 filter_done high outside WAIT_DONE SHALL be ignored.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, pix_valid 0, pix_data 0, busy 0, frame_done 0, timeout 0, and clear all counters.
REQ-036 Reset mid-STREAM SHALL abort the frame with no further pix_valid; a later start SHALL stream from address 0.
REQ-037 Frame memory contents SHALL NOT be reset.

Structure
REQ-038 A shared package SHALL hold the state enum and the default N and M constants used with the edge filter.
REQ-039 The frame memory SHALL be a sub-module, frame_ram: simple dual-port, synchronous read, parameterized depth and width.
REQ-040 Pixel counter and timeout counter SHALL be separate registers.

Verification (N=3, M=4, TIMEOUT=16)
REQ-041 Load mem[k]=k+8'h10 for k=0..11, pulse start at edge t -> pix_valid high from t+2 to t+13, data 10..1B in order, then low.
REQ-042 After the stream, hold filter_done=0 for 5 cycles then raise it -> one frame_done pulse, busy drops the same cycle, timeout stays 0.
REQ-043 Never raise filter_done -> timeout=1 16 cycles after WAIT_DONE entry, no frame_done, IDLE reached.
REQ-044 Pulse start and load_en (addr 0, 8'hAA) in the same cycle; during the stream, pulse start and load_en (addr 5, 8'h55) -> first pixel AA, second start and mid-stream write ignored, mem[5] unchanged.
REQ-045 Assert rst_n=0 on the 6th valid pixel -> pix_valid, busy 0 immediately; then start -> the full 12-pixel frame streams again from address 0 with the original data.
REQ-046 Write to load_addr=12 (out of range), then stream -> frame unchanged and no pixel index wrap corruption.

Source files
------------

// File: rtl/pixel_frame_streamer_pkg.sv
// rtl/pixel_frame_streamer_pkg.sv - shared types and constants for the pixel frame streamer
//
// Purpose : FSM state encoding and the default frame geometry shared with the
//           downstream edge filter.
// Ports   : none (package)

package pixel_frame_streamer_pkg;

  // Default frame geometry, matched to the edge filter's build-time size.
  localparam int unsigned DEF_N = 450;  // rows
  localparam int unsigned DEF_M = 600;  // columns

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRIME     = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pixel_frame_streamer_frame_ram.sv
// rtl/pixel_frame_streamer_frame_ram.sv - simple dual-port frame memory, synchronous read
//
// Purpose : DEPTH x WIDTH storage with one write port and one read port.
//           Read data appears one cycle after the address is presented.
//           Contents are deliberately not reset.
// Ports   : clk      - clock
//           we_i     - write enable
//           waddr_i  - write address
//           wdata_i  - write data
//           re_i     - read enable
//           raddr_i  - read address
//           rdata_o  - registered read data

module frame_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_frame_streamer.sv
// rtl/pixel_frame_streamer.sv - streams one stored frame to the edge filter per start request
//
// Purpose : Holds an N*M byte frame loaded while idle. On start, streams every
//           pixel in raster order as an unbroken pix_valid burst, then waits
//           for the filter to report completion (or times out).
// Ports   : clk, rst_n              - clock, asynchronous active-low reset
//           load_en/addr/data       - frame write port (honoured only in IDLE)
//           start                   - stream request (honoured only in IDLE)
//           filter_done             - completion level from the filter
//           pix_valid, pix_data     - pixel stream to the filter
//           busy                    - high whenever not IDLE
//           frame_done              - one-cycle completion pulse
//           timeout                 - sticky, filter did not finish in time

module pixel_frame_streamer
  import pixel_frame_streamer_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned M       = DEF_M,
  parameter int unsigned TIMEOUT = 2**20,
  parameter int unsigned AW      = (N * M > 1) ? $clog2(N * M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic          filter_done,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic          busy,
  output logic          frame_done,
  output logic          timeout
);

  localparam int unsigned DEPTH = N * M;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW:0]   DEPTH_A  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;   // index of the pixel emitted on the next STREAM edge
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          pix_valid_q, pix_valid_d;
  logic [7:0]    pix_data_q, pix_data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_q, timeout_d;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;

  // Writes are accepted only while idle and inside the frame.
  assign ram_we = (state_q == ST_IDLE) && load_en && ({1'b0, load_addr} < DEPTH_A);

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_frame_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    tmo_cnt_d    = tmo_cnt_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = 8'h00;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    ram_re       = 1'b0;
    ram_raddr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PRIME;
          timeout_d = 1'b0;
          rd_addr_d = '0;
          tmo_cnt_d = '0;
        end
      end

      // Fetch pixel 0 so the RAM output is ready on the first STREAM edge.
      ST_PRIME: begin
        ram_re    = 1'b1;
        ram_raddr = '0;
        state_d   = ST_STREAM;
      end

      // Emit the pixel fetched last cycle while reading one ahead; the
      // one-ahead read keeps pix_valid gap-free across the whole frame.
      ST_STREAM: begin
        pix_valid_d = 1'b1;
        pix_data_d  = ram_rdata;
        ram_re      = 1'b1;
        if (rd_addr_q == LAST_A) begin
          ram_raddr = '0;
          rd_addr_d = '0;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_DONE;
        end else begin
          ram_raddr = rd_addr_q + AW'(1);
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end

      // Completion wins over an expiring count in the same cycle.
      ST_WAIT_DONE: begin
        if (filter_done) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      tmo_cnt_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign timeout    = timeout_q;

endmodule
